moore_pattern_detector: RTL and testbench

Parametrised Moore-type serial pattern detector, the generalised successor of the team's fixed 2-bit, 4-state Moore FSMs. It samples a 1-bit serial stream under a valid qualifier and compares the last `PAT_W` accepted bits against a runtime-loadable pattern. It asserts a registered, state-derived match output and keeps a saturating match counter. Overlapping or non-overlapping detection is selectable at runtime. It sits between a serial front end (sampled bit plus strobe) and control logic that consumes match events.

---
 rtl/moore_pattern_detector.sv | 135 +++++++++++++
 tb/tb_moore_pattern_detector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/moore_pattern_detector.sv
// Moore serial pattern detector.
// Accepts one serial bit per valid strobe and compares the last PAT_W accepted
// bits against a runtime-loadable pattern. The state encodes how full the
// history is and whether it matches. The match output is registered and
// derived from the state. A saturating counter records every entry into MATCH,
// including MATCH->MATCH steps under overlapping detection.
module moore_pattern_detector #(
    parameter int               PAT_W    = 4,
    parameter int               CNT_W    = 8,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             valid_in,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap_en,
    output logic             y_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PAT_W-1:0]  HIST_ZERO = {PAT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_ARMED = 2'b10,
        ST_MATCH = 2'b11
    } state_t;

    // Saturating increment: the counter sticks at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = v + CNT_ONE;
        end
        return res;
    endfunction

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_y;

    state_t             w_state_n;
    logic [PAT_W-1:0]   w_pat_n;
    logic [PAT_W-1:0]   w_hist_n;
    logic [FILL_W-1:0]  w_fill_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_y_n;

    // Next-state logic. Load has priority over accept; with neither, hold.
    always_comb begin
        w_state_n = r_state;
        w_pat_n   = r_pat;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_cnt_n   = r_cnt;

        if (load) begin
            // A new pattern discards the history. The bit on this edge is dropped.
            w_pat_n   = pattern_in;
            w_hist_n  = HIST_ZERO;
            w_fill_n  = FILL_ZERO;
            w_state_n = ST_IDLE;
        end else if (valid_in) begin
            if ((r_state == ST_MATCH) && !overlap_en) begin
                // Non-overlapping: the matched bits are consumed, so restart.
                w_hist_n = {{(PAT_W-1){1'b0}}, x_in};
                w_fill_n = FILL_ONE;
            end else begin
                w_hist_n = {r_hist[PAT_W-2:0], x_in};
                if (r_fill == FILL_MAX) begin
                    w_fill_n = FILL_MAX;
                end else begin
                    w_fill_n = r_fill + FILL_ONE;
                end
            end

            // The fill level gates the compare, so unfilled bits cannot match.
            if ((w_fill_n == FILL_MAX) && (w_hist_n == r_pat)) begin
                w_state_n = ST_MATCH;
                w_cnt_n   = sat_inc(r_cnt);
            end else if (w_fill_n == FILL_MAX) begin
                w_state_n = ST_ARMED;
            end else begin
                w_state_n = ST_SHIFT;
            end
        end else begin
            w_state_n = r_state;
        end

        case (w_state_n)
            ST_MATCH: w_y_n = 1'b1;
            default:  w_y_n = 1'b0;
        endcase
    end

    // State, history, pattern, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pat   <= PAT_INIT;
            r_hist  <= HIST_ZERO;
            r_fill  <= FILL_ZERO;
            r_cnt   <= {CNT_W{1'b0}};
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pat   <= w_pat_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_cnt   <= w_cnt_n;
            r_y     <= w_y_n;
        end
    end

    assign y_out     = r_y;
    assign state_out = r_state;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Directed bench for moore_pattern_detector. It uses a default instance
// (CNT_W=8) and a narrow-counter instance (CNT_W=2). Both instances share the
// same inputs.
module tb_moore_pattern_detector;

    logic       clock;
    logic       reset;
    logic       x_in;
    logic       valid_in;
    logic       load;
    logic [3:0] pattern_in;
    logic       overlap_en;

    logic       y_out;
    logic [1:0] state_out;
    logic [7:0] match_cnt;

    logic       y_out2;
    logic [1:0] state_out2;
    logic [1:0] match_cnt2;

    int total;
    int bad;

    moore_pattern_detector #(.PAT_W(4), .CNT_W(8), .PAT_INIT(4'b1011)) dut (
        .clock(clock), .reset(reset), .x_in(x_in), .valid_in(valid_in),
        .load(load), .pattern_in(pattern_in), .overlap_en(overlap_en),
        .y_out(y_out), .state_out(state_out), .match_cnt(match_cnt)
    );

    moore_pattern_detector #(.PAT_W(4), .CNT_W(2), .PAT_INIT(4'b1011)) dut2 (
        .clock(clock), .reset(reset), .x_in(x_in), .valid_in(valid_in),
        .load(load), .pattern_in(pattern_in), .overlap_en(overlap_en),
        .y_out(y_out2), .state_out(state_out2), .match_cnt(match_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic x);
        valid_in = v;
        x_in     = x;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    logic [6:0] stream;
    logic [1:0] exp_ov [7];
    logic [1:0] exp_nov[7];
    logic [3:0] gap_bits;
    logic [3:0] ld_bits;

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        x_in       = 1'b0;
        valid_in   = 1'b0;
        load       = 1'b0;
        pattern_in = 4'b0000;
        overlap_en = 1'b1;
        stream     = 7'b1011011;
        exp_ov     = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
        exp_nov    = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
        gap_bits   = 4'b1011;
        ld_bits    = 4'b0110;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_y", 32'(y_out), 32'd0);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);

        // Overlapping detection.
        overlap_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream[6-i]);
            chk($sformatf("ov_state%0d", i+1), 32'(state_out), 32'(exp_ov[i]));
            chk($sformatf("ov_y%0d", i+1), 32'(y_out), ((i == 3) || (i == 6)) ? 32'd1 : 32'd0);
        end
        chk("ov_cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping detection.
        do_reset();
        overlap_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream[6-i]);
            chk($sformatf("nov_state%0d", i+1), 32'(state_out), 32'(exp_nov[i]));
        end
        chk("nov_cnt", 32'(match_cnt), 32'd1);

        // Valid gaps: 1011 with three idle cycles after each bit.
        do_reset();
        overlap_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gap_bits[3-i]);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b1);
                chk($sformatf("gap_y%0d_%0d", i+1, g), 32'(y_out), (i == 3) ? 32'd1 : 32'd0);
            end
        end
        chk("gap_state", 32'(state_out), 32'd3);
        chk("gap_cnt", 32'(match_cnt), 32'd1);

        // Load mid-stream after 1,0,1; the bit on the load edge is discarded.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("pre_load_state", 32'(state_out), 32'd2);
        load       = 1'b1;
        pattern_in = 4'b0110;
        step(1'b1, 1'b1);
        load       = 1'b0;
        pattern_in = 4'b1111;   // a change without load must be ignored
        chk("load_state", 32'(state_out), 32'd0);
        chk("load_cnt_kept", 32'(match_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ld_bits[3-i]);
            chk($sformatf("ld_state%0d", i+1), 32'(state_out), (i == 3) ? 32'd3 : 32'd1);
        end
        chk("ld_cnt", 32'(match_cnt), 32'd2);

        // Reset while in MATCH.
        do_reset();
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gap_bits[3-i]);
        end
        chk("rst_pat_back", 32'(y_out), 32'd1);
        chk("rst_pat_cnt", 32'(match_cnt), 32'd1);

        // Load while in MATCH drops y_out after that edge.
        load       = 1'b1;
        pattern_in = 4'b1111;
        step(1'b0, 1'b0);
        load       = 1'b0;
        chk("ldm_y", 32'(y_out), 32'd0);
        chk("ldm_state", 32'(state_out), 32'd0);

        // Counter saturation on the 2-bit instance: pattern 1111, eight 1s.
        do_reset();
        load       = 1'b1;
        pattern_in = 4'b1111;
        step(1'b0, 1'b0);
        load       = 1'b0;
        overlap_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("sat_y%0d", i), 32'(y_out2), (i >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("sat_cnt%0d", i), 32'(match_cnt2),
                (i < 4) ? 32'd0 : ((i == 4) ? 32'd1 : ((i == 5) ? 32'd2 : 32'd3)));
        end
        chk("wide_cnt", 32'(match_cnt), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
